// File: rtl/dmac_memory_burst_splitter.sv
`default_nettype none
// ============================================================================
// Module   : dmac_memory_burst_splitter
// Brief    : Pops DMA commands and splits them into bus bursts that respect the
//            maximum burst length and address-boundary limits.
// Revision : 1.0 - initial release
// ============================================================================
module dmac_memory_burst_splitter #(
  parameter int W_EXT_A    = 32,
  parameter int W_EXT_D    = 32,
  parameter int W_BLEN     = 8,
  parameter int W_BOUNDARY = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W_EXT_A-1:0] cmd_ext_addr,
  input  logic [W_EXT_A-1:0] cmd_core_addr,
  input  logic               cmd_read_enable,
  input  logic               cmd_write_enable,
  input  logic [W_EXT_A:0]   cmd_word_size,
  input  logic               cmd_empty,
  output logic               cmd_deq,
  output logic [W_EXT_A-1:0] req_addr,
  output logic [W_BLEN-1:0]  req_len,
  output logic               req_write,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [W_EXT_A-1:0] iss_core_addr,
  output logic               iss_read_enable,
  output logic               iss_write_enable,
  output logic               iss_burst_trunc,
  output logic [W_EXT_A:0]   iss_word_size,
  output logic               iss_enq,
  input  logic               iss_full,
  output logic               busy
);

  localparam int                 c_LB          = $clog2(W_EXT_D / 8);
  localparam int                 c_BW          = W_BOUNDARY - c_LB;
  localparam logic [W_EXT_A:0]   c_ONE         = (W_EXT_A + 1)'(1);
  localparam logic [W_EXT_A:0]   c_MAX_BURST   = c_ONE << W_BLEN;
  localparam logic [W_EXT_A:0]   c_BOUND_WORDS = c_ONE << c_BW;
  localparam logic [W_EXT_A-1:0] c_LOW_MASK    = W_EXT_A'((1 << c_LB) - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_CALC  = 2'd1;
  localparam logic [1:0] c_ISSUE = 2'd2;
  localparam logic [1:0] c_WAIT  = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nx;
  logic [W_EXT_A-1:0] r_ext_addr;
  logic [W_EXT_A-1:0] r_core_addr;
  logic [W_EXT_A:0]   r_remaining;
  logic [W_EXT_A:0]   r_beats;
  logic               r_is_read;

  logic               w_take;
  logic               w_calc_go;
  logic               w_hs;
  logic               w_cmd_ok;
  logic               w_last;
  logic [W_EXT_A:0]   w_rem_next;
  logic [c_BW-1:0]    w_word_off;
  logic [W_EXT_A:0]   w_to_bound;
  logic [W_EXT_A:0]   w_min_len;
  logic [W_EXT_A:0]   w_beats;

  assign w_cmd_ok   = (cmd_word_size != '0) && (cmd_read_enable || cmd_write_enable);
  assign w_rem_next = r_remaining - r_beats;
  assign w_last     = (w_rem_next == '0);

  // Words left before the next boundary; the address is word aligned so this is >= 1.
  assign w_word_off = r_ext_addr[W_BOUNDARY-1:c_LB];
  assign w_to_bound = c_BOUND_WORDS - {{(W_EXT_A + 1 - c_BW){1'b0}}, w_word_off};
  assign w_min_len  = (r_remaining < c_MAX_BURST) ? r_remaining : c_MAX_BURST;
  assign w_beats    = (w_min_len < w_to_bound) ? w_min_len : w_to_bound;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      c_IDLE:  if (!cmd_empty) w_state_nx = w_cmd_ok ? c_CALC : c_WAIT;
      c_CALC:  if (!iss_full) w_state_nx = c_ISSUE;
      c_ISSUE: if (req_valid && req_ready) w_state_nx = w_last ? c_IDLE : c_CALC;
      c_WAIT:  w_state_nx = c_IDLE;
      default: w_state_nx = c_IDLE;
    endcase
  end

  always_comb begin
    w_take    = 1'b0;
    w_calc_go = 1'b0;
    w_hs      = 1'b0;
    case (r_state)
      c_IDLE:  w_take    = !cmd_empty;
      c_CALC:  w_calc_go = !iss_full;
      c_ISSUE: w_hs      = req_valid && req_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_deq          <= 1'b0;
      req_addr         <= '0;
      req_len          <= '0;
      req_write        <= 1'b0;
      req_valid        <= 1'b0;
      iss_core_addr    <= '0;
      iss_read_enable  <= 1'b0;
      iss_write_enable <= 1'b0;
      iss_burst_trunc  <= 1'b0;
      iss_word_size    <= '0;
      iss_enq          <= 1'b0;
      busy             <= 1'b0;
      r_ext_addr       <= '0;
      r_core_addr      <= '0;
      r_remaining      <= '0;
      r_beats          <= '0;
      r_is_read        <= 1'b0;
    end else begin
      cmd_deq <= w_take;
      iss_enq <= w_hs;
      busy    <= (w_state_nx != c_IDLE);

      if (w_take) begin
        r_ext_addr  <= cmd_ext_addr & ~c_LOW_MASK;
        r_core_addr <= cmd_core_addr;
        r_remaining <= cmd_word_size;
        r_is_read   <= cmd_read_enable;
      end

      // Request fields are refreshed while waiting for issued-queue space.
      if (r_state == c_CALC) begin
        r_beats   <= w_beats;
        req_addr  <= r_ext_addr;
        req_len   <= W_BLEN'(w_beats - c_ONE);
        req_write <= !r_is_read;
        req_valid <= w_calc_go;
      end

      if (w_hs) begin
        req_valid        <= 1'b0;
        iss_core_addr    <= r_core_addr;
        iss_read_enable  <= r_is_read;
        iss_write_enable <= !r_is_read;
        iss_burst_trunc  <= !w_last;
        iss_word_size    <= r_beats;
        r_ext_addr       <= r_ext_addr + W_EXT_A'(r_beats << c_LB);
        r_core_addr      <= r_core_addr + W_EXT_A'(r_beats);
        r_remaining      <= w_rem_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmac_memory_burst_splitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmac_memory_burst_splitter
// Brief    : Randomized scoreboard bench for the DMA burst splitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmac_memory_burst_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd_ext_addr;
  logic [31:0] cmd_core_addr;
  logic        cmd_read_enable;
  logic        cmd_write_enable;
  logic [32:0] cmd_word_size;
  logic        cmd_empty;
  logic        cmd_deq;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        req_write;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] iss_core_addr;
  logic        iss_read_enable;
  logic        iss_write_enable;
  logic        iss_burst_trunc;
  logic [32:0] iss_word_size;
  logic        iss_enq;
  logic        iss_full;
  logic        busy;

  dmac_memory_burst_splitter #(
    .W_EXT_A(32), .W_EXT_D(32), .W_BLEN(8), .W_BOUNDARY(12)
  ) u_dut (
    .clk(clk), .rst(rst),
    .cmd_ext_addr(cmd_ext_addr), .cmd_core_addr(cmd_core_addr),
    .cmd_read_enable(cmd_read_enable), .cmd_write_enable(cmd_write_enable),
    .cmd_word_size(cmd_word_size), .cmd_empty(cmd_empty), .cmd_deq(cmd_deq),
    .req_addr(req_addr), .req_len(req_len), .req_write(req_write),
    .req_valid(req_valid), .req_ready(req_ready),
    .iss_core_addr(iss_core_addr), .iss_read_enable(iss_read_enable),
    .iss_write_enable(iss_write_enable), .iss_burst_trunc(iss_burst_trunc),
    .iss_word_size(iss_word_size), .iss_enq(iss_enq), .iss_full(iss_full),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] ext; logic [31:0] core; logic rd; logic wr; logic [32:0] size; } cmd_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; logic wr; } req_t;
  typedef struct { logic [31:0] core; logic rd; logic wr; logic trunc; logic [32:0] size; } iss_t;

  cmd_t cmd_q[$];
  req_t exp_req[$];
  iss_t exp_iss[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_pushed = 0;
  int n_deq    = 0;
  int ready_pct = 100;
  int full_pct  = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic update_head();
    if (cmd_q.size() == 0) begin
      cmd_empty        = 1'b1;
      cmd_ext_addr     = '0;
      cmd_core_addr    = '0;
      cmd_read_enable  = 1'b0;
      cmd_write_enable = 1'b0;
      cmd_word_size    = '0;
    end else begin
      cmd_empty        = 1'b0;
      cmd_ext_addr     = cmd_q[0].ext;
      cmd_core_addr    = cmd_q[0].core;
      cmd_read_enable  = cmd_q[0].rd;
      cmd_write_enable = cmd_q[0].wr;
      cmd_word_size    = cmd_q[0].size;
    end
  endtask

  task automatic push_cmd(input logic [31:0] ext, input logic [31:0] core,
                          input logic rd, input logic wr, input logic [32:0] size);
    cmd_t c;
    c.ext = ext; c.core = core; c.rd = rd; c.wr = wr; c.size = size;
    cmd_q.push_back(c);
    n_pushed++;
    update_head();
  endtask

  function automatic bit cmd_valid(input cmd_t c);
    return (c.size != 0) && (c.rd || c.wr);
  endfunction

  // Reference model: carve a command into bursts with plain arithmetic.
  task automatic expand(input cmd_t c);
    longint unsigned addr, core, rem, to_bound, b;
    req_t r;
    iss_t s;
    if (!cmd_valid(c)) return;
    addr = longint'(c.ext) & 64'hFFFF_FFFC;
    core = longint'(c.core);
    rem  = longint'(c.size);
    while (rem > 0) begin
      to_bound = (4096 - (addr % 4096)) / 4;
      b = rem;
      if (b > 256) b = 256;
      if (b > to_bound) b = to_bound;
      r.addr = 32'(addr); r.len = 8'(b - 1); r.wr = !c.rd;
      exp_req.push_back(r);
      s.core = 32'(core); s.rd = c.rd; s.wr = !c.rd; s.trunc = (rem > b); s.size = 33'(b);
      exp_iss.push_back(s);
      addr = (addr + b * 4) & 64'hFFFF_FFFF;
      core = (core + b) & 64'hFFFF_FFFF;
      rem  = rem - b;
    end
  endtask

  always @(posedge clk) begin
    #1;
    req_ready = (int'($urandom_range(0, 99)) < ready_pct);
    iss_full  = (int'($urandom_range(0, 99)) < full_pct);
  end

  logic        hs_prev = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] addr_prev;
  logic [7:0]  len_prev;
  logic        wr_prev;
  int          cyc = 0;
  int          last_deq = -100;
  bit          last_valid = 1'b0;
  cmd_t        pop_c;
  req_t        er;
  iss_t        ei;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      hs_prev    = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check_val("iss_enq_timing", iss_enq, hs_prev);
      if (stall_prev) begin
        check_val("hold_valid", req_valid, 1'b1);
        check_val("hold_addr", req_addr, addr_prev);
        check_val("hold_len", req_len, len_prev);
        check_val("hold_write", req_write, wr_prev);
      end
      if (req_valid && req_ready) begin
        check_val("req_expected", exp_req.size() > 0, 1'b1);
        if (exp_req.size() > 0) begin
          er = exp_req.pop_front();
          check_val("req_addr", req_addr, er.addr);
          check_val("req_len", req_len, er.len);
          check_val("req_write", req_write, er.wr);
        end
      end
      if (iss_enq) begin
        check_val("iss_expected", exp_iss.size() > 0, 1'b1);
        if (exp_iss.size() > 0) begin
          ei = exp_iss.pop_front();
          check_val("iss_core_addr", iss_core_addr, ei.core);
          check_val("iss_dir", {iss_read_enable, iss_write_enable}, {ei.rd, ei.wr});
          check_val("iss_trunc", iss_burst_trunc, ei.trunc);
          check_val("iss_word_size", iss_word_size, ei.size);
        end
      end
      if (cmd_deq) begin
        check_val("deq_nonempty", cmd_q.size() > 0, 1'b1);
        check_val("deq_spacing", (cyc - last_deq) >= (last_valid ? 3 : 2), 1'b1);
        if (cmd_q.size() > 0) begin
          pop_c = cmd_q.pop_front();
          last_valid = cmd_valid(pop_c);
          expand(pop_c);
          update_head();
        end
        last_deq = cyc;
        n_deq++;
      end
      hs_prev    = req_valid && req_ready;
      stall_prev = req_valid && !req_ready;
      addr_prev  = req_addr;
      len_prev   = req_len;
      wr_prev    = req_write;
    end
  end

  task automatic check_outputs_zero(input string pfx);
    check_val({pfx, "_req"}, {req_addr, req_len, req_write, req_valid, cmd_deq}, '0);
    check_val({pfx, "_iss"}, {iss_core_addr, iss_read_enable, iss_write_enable,
                              iss_burst_trunc, iss_enq}, '0);
    check_val({pfx, "_iss_size"}, iss_word_size, '0);
    check_val({pfx, "_busy"}, busy, 1'b0);
  endtask

  task automatic wait_idle(input int budget);
    int t;
    int pending;
    t = 0;
    pending = 1;
    repeat (2) @(negedge clk);
    while (t < budget) begin
      pending = cmd_q.size() + exp_req.size() + exp_iss.size() + int'(busy) + int'(cmd_deq);
      if (pending == 0) break;
      @(negedge clk);
      t++;
    end
    if (t >= budget) check_val("idle_timeout", pending, 0);
  endtask

  task automatic wait_req_valid(input int budget);
    int t;
    t = 0;
    while (!req_valid && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) check_val("req_valid_timeout", req_valid, 1'b1);
  endtask

  initial begin
    logic [31:0] r32;
    logic [31:0] ext;
    int          e;
    int          t;
    logic [32:0] sz;

    rst = 1'b1;
    req_ready = 1'b1;
    iss_full = 1'b0;
    update_head();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #2 rst = 1'b0;

    push_cmd(32'h0000_1000, 32'h20, 1'b1, 1'b0, 33'd16);
    wait_idle(500);
    push_cmd(32'h0000_0FF0, 32'h40, 1'b0, 1'b1, 33'd8);
    wait_idle(500);
    push_cmd(32'h0000_0000, 32'h100, 1'b1, 1'b0, 33'd600);
    wait_idle(500);

    push_cmd(32'h0000_2000, 32'h0, 1'b1, 1'b0, 33'd0);
    push_cmd(32'h0000_2000, 32'h0, 1'b0, 1'b0, 33'd5);
    push_cmd(32'h0000_2000, 32'h80, 1'b0, 1'b1, 33'd5);
    wait_idle(500);

    // Address wrap-around with both enables set (read wins).
    push_cmd(32'hFFFF_FFF0, 32'hFFFF_FFFE, 1'b1, 1'b1, 33'd20);
    wait_idle(500);

    ready_pct = 0;
    repeat (2) @(posedge clk);
    #2 push_cmd(32'h0000_3000, 32'h10, 1'b1, 1'b0, 33'd300);
    wait_req_valid(20);
    repeat (5) @(negedge clk);
    check_val("stall_valid", req_valid, 1'b1);
    check_val("stall_addr", req_addr, 32'h0000_3000);
    check_val("stall_len", req_len, 8'd255);
    check_val("stall_no_enq", iss_enq, 1'b0);
    ready_pct = 100;
    wait_idle(500);

    full_pct = 100;
    repeat (3) @(posedge clk);
    #2 push_cmd(32'h0000_5000, 32'h0, 1'b0, 1'b1, 33'd4);
    repeat (8) begin
      @(negedge clk);
      check_val("full_blocks_valid", req_valid, 1'b0);
    end
    full_pct = 0;
    wait_idle(500);

    // Reset in the middle of a multi-burst command.
    push_cmd(32'h0000_0000, 32'h200, 1'b1, 1'b0, 33'd600);
    push_cmd(32'h0000_6000, 32'h300, 1'b0, 1'b1, 33'd10);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!iss_enq && t < 100);
    if (t >= 100) check_val("first_iss_timeout", iss_enq, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    exp_req.delete();
    exp_iss.delete();
    @(negedge clk);
    check_outputs_zero("midrst");
    wait_idle(500);

    ready_pct = 70;
    full_pct  = 20;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #2;
      r32 = $urandom;
      if ($urandom_range(0, 2) == 0)
        ext = (r32 & 32'hFFFF_F000) | (32'h0000_0FC0 + ($urandom_range(0, 15) << 2));
      else
        ext = r32 & 32'hFFFF_FFFC;
      sz = ($urandom_range(0, 7) == 0) ? 33'd0 : 33'($urandom_range(1, 700));
      e = int'($urandom_range(0, 9));
      push_cmd(ext, $urandom, (e >= 1 && e < 5) || e >= 8, e >= 5, sz);
    end
    wait_idle(20000);

    check_val("deq_count", n_deq, n_pushed);
    check_val("req_left", exp_req.size(), 0);
    check_val("iss_left", exp_iss.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
